// File: rtl/seg_scan_if.sv
// Bundle between user logic and the multiplexed 7-segment scan driver.
// load is a single-cycle strobe with no back-pressure: it is always accepted on the clock edge where it is high.
interface seg_scan_if #(
    parameter int DIGITS = 6
);
    logic [4*DIGITS-1:0] data_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic                load;
    logic                frame_done;
    logic [7:0]          seg_out;
    logic [DIGITS-1:0]   sel_out;

    modport master (
        output data_in, dp_in, blank_in, load,
        input  frame_done, seg_out, sel_out
    );

    modport slave (
        input  data_in, dp_in, blank_in, load,
        output frame_done, seg_out, sel_out
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment driver with frame-aligned double buffering.
// The outputs are registered and lag the slot/digit counters by one clock.
module seg_scan_driver #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int SCAN_FREQ      = 1000,
    parameter int DIGITS         = 6,
    parameter int GAP_CYCLES     = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int DIV = CLK_FREQ / SCAN_FREQ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(DIGITS);
    localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_pend_data, r_act_data;
    logic [DIGITS-1:0]   r_pend_dp, r_act_dp;
    logic [DIGITS-1:0]   r_pend_blank, r_act_blank;
    logic                r_pend_valid;
    logic                r_frame_done;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_sel;

    logic                w_slot_end;
    logic                w_last_digit;
    logic                w_frame_end;
    logic [3:0]          w_nibble;
    logic [6:0]          w_glyph;
    logic                w_slot_on;
    logic [7:0]          w_seg;
    logic [DIGITS-1:0]   w_sel;

    assign w_slot_end   = (r_cnt == CW'(DIV - 1));
    assign w_last_digit = (r_idx == IW'(DIGITS - 1));
    assign w_frame_end  = w_slot_end && w_last_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= w_last_digit ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A load landing on the frame boundary bypasses the pending stage so it shows in the very next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_valid <= 1'b0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= {DIGITS{1'b1}};
        end else if (w_frame_end) begin
            if (bus.load) begin
                r_act_data  <= bus.data_in;
                r_act_dp    <= bus.dp_in;
                r_act_blank <= bus.blank_in;
            end else if (r_pend_valid) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
            end
            r_pend_valid <= 1'b0;
        end else if (bus.load) begin
            r_pend_data  <= bus.data_in;
            r_pend_dp    <= bus.dp_in;
            r_pend_blank <= bus.blank_in;
            r_pend_valid <= 1'b1;
        end
    end

    assign w_nibble = r_act_data[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_glyph = 7'h00;
        case (w_nibble)
            4'h0: w_glyph = 7'h3F;
            4'h1: w_glyph = 7'h06;
            4'h2: w_glyph = 7'h5B;
            4'h3: w_glyph = 7'h4F;
            4'h4: w_glyph = 7'h66;
            4'h5: w_glyph = 7'h6D;
            4'h6: w_glyph = 7'h7D;
            4'h7: w_glyph = 7'h07;
            4'h8: w_glyph = 7'h7F;
            4'h9: w_glyph = 7'h6F;
            4'hA: w_glyph = 7'h77;
            4'hB: w_glyph = 7'h7C;
            4'hC: w_glyph = 7'h39;
            4'hD: w_glyph = 7'h5E;
            4'hE: w_glyph = 7'h79;
            4'hF: w_glyph = 7'h71;
            default: w_glyph = 7'h00;
        endcase
    end

    // The dead time at the start of every slot keeps the select lines from overlapping across digits.
    assign w_slot_on = (r_cnt >= CW'(GAP_CYCLES)) && !r_act_blank[r_idx];
    assign w_seg     = w_slot_on ? {r_act_dp[r_idx], w_glyph} : 8'h00;
    assign w_sel     = w_slot_on ? ({{(DIGITS-1){1'b0}}, 1'b1} << r_idx) : {DIGITS{1'b0}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= SEG_OFF;
            r_sel        <= SEL_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= SEG_ACTIVE_LOW ? ~w_seg : w_seg;
            r_sel        <= SEL_ACTIVE_LOW ? ~w_sel : w_sel;
            r_frame_done <= w_frame_end;
        end
    end

    assign bus.seg_out    = r_seg;
    assign bus.sel_out    = r_sel;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: DIV=10, GAP=2, six digits, both outputs active-low.
module tb_seg_scan_driver;
  localparam int DIGITS = 6;
  localparam int SLOT   = 10;
  localparam int FRAME  = SLOT * DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seg_scan_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_driver #(
    .CLK_FREQ(1000), .SCAN_FREQ(100), .DIGITS(DIGITS), .GAP_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int j_pos        = 1;

  logic [23:0] m_act_data, m_pend_data, m_in_data;
  logic [5:0]  m_act_dp, m_pend_dp, m_in_dp;
  logic [5:0]  m_act_blank, m_pend_blank, m_in_blank;
  logic        m_pend_valid, m_load_now;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act_data   = '0;
    m_act_dp     = '0;
    m_act_blank  = 6'h3F;
    m_pend_valid = 1'b0;
    m_load_now   = 1'b0;
  endtask

  // one clock: check the outputs for frame position j_pos, then advance the buffer model
  task automatic step_check();
    int k, c;
    logic [7:0] e_seg;
    logic [5:0] e_sel;
    @(negedge clk);
    k = (j_pos - 1) / SLOT;
    c = (j_pos - 1) % SLOT;
    if (c < 2 || m_act_blank[k]) begin
      e_seg = 8'hFF;
      e_sel = 6'h3F;
    end else begin
      e_seg = ~{m_act_dp[k], glyph(m_act_data[4*k +: 4])};
      e_sel = ~(6'b000001 << k);
    end
    check($sformatf("seg j%0d", j_pos), {24'h0, bus.seg_out}, {24'h0, e_seg});
    check($sformatf("sel j%0d", j_pos), {26'h0, bus.sel_out}, {26'h0, e_sel});
    check($sformatf("frame_done j%0d", j_pos), {31'h0, bus.frame_done}, {31'h0, (j_pos == FRAME)});
    if (j_pos == FRAME) begin
      if (m_load_now) begin
        m_act_data = m_in_data; m_act_dp = m_in_dp; m_act_blank = m_in_blank;
      end else if (m_pend_valid) begin
        m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
      end
      m_pend_valid = 1'b0;
    end else if (m_load_now) begin
      m_pend_data = m_in_data; m_pend_dp = m_in_dp; m_pend_blank = m_in_blank;
      m_pend_valid = 1'b1;
    end
    m_load_now = 1'b0;
    j_pos = (j_pos == FRAME) ? 1 : j_pos + 1;
  endtask

  task automatic run(input int n);
    repeat (n) step_check();
  endtask

  task automatic run_to(input int pos);
    while (j_pos != pos) step_check();
  endtask

  // driver: one-cycle load strobe captured on the next rising edge
  task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl);
    bus.data_in  = d;
    bus.dp_in    = dp;
    bus.blank_in = bl;
    bus.load     = 1'b1;
    m_in_data = d; m_in_dp = dp; m_in_blank = bl;
    m_load_now = 1'b1;
    step_check();
    bus.load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " seg"}, {24'h0, bus.seg_out}, 32'hFF);
    check({tag, " sel"}, {26'h0, bus.sel_out}, 32'h3F);
    check({tag, " frame_done"}, {31'h0, bus.frame_done}, 32'h0);
  endtask

  initial begin
    bus.data_in  = '0;
    bus.dp_in    = '0;
    bus.blank_in = '0;
    bus.load     = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b0;
    rst_n = 1'b1;
    j_pos = 1;

    // 1: dark display for two frames, frame_done every 60 clocks
    run(2 * FRAME);

    // 2: mid-frame load stays pending until the frame boundary
    run(24);
    do_load(24'h543210, 6'h00, 6'h00);
    run_to(1);
    run(FRAME);

    // 3: last of two loads in a frame wins
    run(10);
    do_load(24'h111111, 6'h00, 6'h00);
    run(20);
    do_load(24'hABCDEF, 6'h00, 6'h00);
    run_to(1);
    run(FRAME);

    // 4: load on the frame_end cycle shows in the very next frame, overriding a pending one
    run(10);
    do_load(24'h777777, 6'h00, 6'h00);
    run_to(FRAME);
    do_load(24'h999999, 6'h00, 6'h00);
    run(FRAME);

    // 5: blank digit 2, decimal point on digit 0
    run(5);
    do_load(24'h543210, 6'b000001, 6'b000100);
    run_to(1);
    run(FRAME);

    // 6: asynchronous reset in the middle of digit 3 discards pending and active data
    run(10);
    do_load(24'h222222, 6'h00, 6'h00);
    run_to(36);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    model_reset();
    @(negedge clk);
    check_reset_outputs("held reset");
    rst_n = 1'b1;
    j_pos = 1;
    run(2 * FRAME);
    do_load(24'hFEDCBA, 6'h00, 6'h00);
    run_to(1);
    run(FRAME);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Multiplexed 7-segment display driver for the board's common-anode digit array; the output-side counterpart to the key-scan input logic. It accepts hex nibbles, decimal points and per-digit blank flags from user logic, hex-decodes them and time-multiplexes digit selects at a fixed scan rate. New data is double-buffered and committed only at frame boundaries, so a frame never shows mixed old and new values.

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
SCAN_FREQ, 1000, per-digit slot rate in Hz; DIV = CLK_FREQ/SCAN_FREQ clocks per slot (DIV >= GAP_CYCLES+2)
DIGITS, 6, number of digits (2..8)
GAP_CYCLES, 16, anti-ghosting dead time at the start of each slot, in clocks
SEG_ACTIVE_LOW, 1, 1 = seg_out low-active
SEL_ACTIVE_LOW, 1, 1 = sel_out low-active

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
data_in  in  4*DIGITS  hex nibble per digit; digit i = data_in[4i+3:4i]; digit 0 is rightmost
dp_in  in  DIGITS  decimal point per digit, 1 = lit
blank_in  in  DIGITS  1 = digit dark (seg and sel inactive for that slot)
load  in  1  single-cycle strobe; captures data_in/dp_in/blank_in into the pending buffer
frame_done  out  1  one-cycle pulse when the last digit slot ends
seg_out  out  8  [0]=a … [6]=g, [7]=dp; registered
sel_out  out  DIGITS  one-hot digit select; registered

Behaviour:
- Slot counter cnt: 0..DIV-1; wraps to 0 after DIV-1; slot_end = (cnt==DIV-1).
- Digit index idx: 0..DIGITS-1; increments on slot_end; wraps DIGITS-1 -> 0; frame_end = slot_end && idx==DIGITS-1.
- frame_done = registered frame_end: high exactly one clock, the cycle after frame_end.
- Buffers: pending {data,dp,blank} and active {data,dp,blank}; pend_valid flag.
  - load: pending <= inputs, pend_valid <= 1. A later load before commit overwrites pending (last one wins).
  - frame_end with pend_valid: active <= pending, pend_valid <= 0.
  - load on the same cycle as frame_end: active <= inputs directly (bypass), pend_valid <= 0.
  - load at any other time never alters active mid-frame.
- Segment decode (active-high internal): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. dp_in maps to bit 7.
- Output per clock (registered, from current cnt/idx/active):
  - cnt < GAP_CYCLES, or active.blank[idx]=1: sel all inactive, seg all off.
  - Otherwise: sel bit idx active, others inactive; seg = decode(active.data[idx]) | dp<<7.
  - Output latency is 1 clock: the outputs reflect the cnt/idx of the previous cycle.
  - Polarity is applied last: invert seg when SEG_ACTIVE_LOW, invert sel when SEL_ACTIVE_LOW.
- Reset (async assert, sync deassert in use):
  - cnt=0, idx=0, pend_valid=0, active.data=0, active.dp=0, active.blank=all 1s (dark display).
  - seg_out=all off (8'hFF when active-low), sel_out=all inactive, frame_done=0.
- Reset mid-frame: pending and active data are discarded; scanning restarts at digit 0 with cnt=0.
- At most one sel bit is active in any cycle, including the cycles around slot transitions.

Test Plan:
1. Params CLK_FREQ=1000, SCAN_FREQ=100 (DIV=10), GAP=2, DIGITS=6. Release reset, no load -> seg_out=8'hFF and sel_out=6'h3F for 2 full frames; frame_done pulses every 60 clocks.
2. load data_in=24'h543210, dp=0, blank=0 mid-frame -> active unchanged until next frame_done. In the following frame, slot k shows sel_out=~(1<<k) and seg_out=~decode(k) (slot 0 -> 8'hC0). sel stays inactive for the first 2 clocks of each slot.
3. Two loads in one frame (24'h111111, then 24'hABCDEF) -> the next frame shows only A,b,C,d,E,F (digit 0 = F -> seg 8'h8E). 24'h111111 is never displayed.
4. load asserted exactly on the frame_end cycle with 24'h999999 -> the very next slot (digit 0) shows 9 (seg 8'h90).
5. blank_in=6'b000100, dp_in=6'b000001 -> digit 2 slot keeps sel inactive and seg=8'hFF; digit 0 seg bit 7 is low.
6. Assert rst_n low mid-slot at idx=3 -> outputs go off and sel inactive asynchronously. After release, scanning restarts at idx=0 with all digits blank until a new load commits.
